// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last time is chosen.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_take,
    output logic o_valid,
    output logic o_gnt
);

    logic r_last;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        o_gnt   = PORT_I;
        o_valid = i_req_i | i_req_d;
        if (i_req_i && i_req_d)
            o_gnt = ~r_last;
        else if (i_req_d)
            o_gnt = PORT_D;
    end

    // NOTE: clocked state uses <= so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= PORT_I;
        else if (i_take)
            r_last <= o_gnt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction and data sides; IDLE -> ACCESS -> RESP per
// transaction, with all outputs registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_gnt;
    logic       r_we;
    logic       w_valid;
    logic       w_gnt;
    logic       w_take;

    assign w_take = (r_state == ST_IDLE) && w_valid;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .i_req_i (i_req),
        .i_req_d (d_req),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_gnt   (w_gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gnt     <= PORT_I;
            r_we      <= 1'b0;
            i_ready   <= 1'b0;
            i_rdata   <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= CNT_LOAD;
                        r_gnt   <= w_gnt;
                        busy    <= 1'b1;
                        if (w_gnt == PORT_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                            r_we      <= d_we;
                            mem_ren   <= !d_we;
                            mem_wen   <= d_we;
                        end else begin
                            // Instruction side is read-only, so write fields are cleared.
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= '0;
                            r_we      <= 1'b0;
                            mem_ren   <= 1'b1;
                            mem_wen   <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        if (r_gnt == PORT_D) begin
                            d_ready <= 1'b1;
                            if (!r_we) d_rdata <= mem_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        i_ready, d_ready, mem_ren, mem_wen, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        i1_req, d1_req, d1_we;
    logic [31:0] i1_addr, d1_addr, d1_wdata, mem1_rdata;
    logic [3:0]  d1_be;
    logic        i1_ready, d1_ready, mem1_ren, mem1_wen, busy1;
    logic [31:0] i1_rdata, d1_rdata, mem1_addr, mem1_wdata;
    logic [3:0]  mem1_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i1_req), .i_addr(i1_addr), .i_ready(i1_ready), .i_rdata(i1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata), .d_be(d1_be),
        .d_ready(d1_ready), .d_rdata(d1_rdata),
        .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_be(mem1_be),
        .mem_ren(mem1_ren), .mem_wen(mem1_wen), .mem_rdata(mem1_rdata), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".i_ready"},   i_ready,   0);
        check({tag, ".d_ready"},   d_ready,   0);
        check({tag, ".i_rdata"},   i_rdata,   0);
        check({tag, ".d_rdata"},   d_rdata,   0);
        check({tag, ".mem_addr"},  mem_addr,  0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".mem_be"},    mem_be,    0);
        check({tag, ".mem_ren"},   mem_ren,   0);
        check({tag, ".mem_wen"},   mem_wen,   0);
        check({tag, ".busy"},      busy,      0);
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_rdata = 0;
        i1_req = 0; d1_req = 0; d1_we = 0; i1_addr = 32'h40; d1_addr = 0; d1_wdata = 0;
        d1_be = 0; mem1_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Instruction read alone
        i_req = 1; i_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ird.acc1.ren",  mem_ren, 1);
        check("ird.acc1.wen",  mem_wen, 0);
        check("ird.acc1.addr", mem_addr, 32'h100);
        check("ird.acc1.busy", busy, 1);
        check("ird.acc1.rdy",  i_ready, 0);
        @(negedge clk);
        check("ird.acc2.ren",  mem_ren, 1);
        check("ird.acc2.rdy",  i_ready, 0);
        @(negedge clk);
        check("ird.resp.rdy",  i_ready, 1);
        check("ird.resp.drdy", d_ready, 0);
        check("ird.resp.ren",  mem_ren, 0);
        check("ird.resp.data", i_rdata, 32'hDEADBEEF);
        check("ird.resp.busy", busy, 1);
        i_req = 0;
        @(negedge clk);
        check("ird.idle.rdy",  i_ready, 0);
        check("ird.idle.busy", busy, 0);
        check("ird.idle.data", i_rdata, 32'hDEADBEEF);

        // Data write alone
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_be = 4'b0011;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("dwr.acc1.wen",   mem_wen, 1);
        check("dwr.acc1.ren",   mem_ren, 0);
        check("dwr.acc1.addr",  mem_addr, 32'h2004);
        check("dwr.acc1.wdata", mem_wdata, 32'h12345678);
        check("dwr.acc1.be",    mem_be, 4'b0011);
        @(negedge clk);
        check("dwr.acc2.wen",   mem_wen, 1);
        check("dwr.acc2.rdy",   d_ready, 0);
        @(negedge clk);
        check("dwr.resp.rdy",   d_ready, 1);
        check("dwr.resp.irdy",  i_ready, 0);
        check("dwr.resp.wen",   mem_wen, 0);
        check("dwr.resp.data",  d_rdata, 0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("dwr.idle.rdy",   d_ready, 0);
        check("dwr.idle.addr",  mem_addr, 32'h2004);
        check("dwr.idle.be",    mem_be, 4'b0011);
        check("dwr.idle.wen",   mem_wen, 0);

        // Round-robin from reset with both held: D, I, D, I
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check($sformatf("rr%0d.ren", t),  mem_ren, 1);
            check($sformatf("rr%0d.addr", t), mem_addr, (t % 2 == 0) ? 32'h400 : 32'h300);
            mem_rdata = 32'hA000_0000 + t;
            @(negedge clk);
            check($sformatf("rr%0d.acc2.ren", t), mem_ren, 1);
            check($sformatf("rr%0d.acc2.rdy", t), {i_ready, d_ready}, 2'b00);
            @(negedge clk);
            check($sformatf("rr%0d.resp.rdy", t), {i_ready, d_ready},
                  (t % 2 == 0) ? 2'b01 : 2'b10);
            if (t % 2 == 0)
                check($sformatf("rr%0d.drdata", t), d_rdata, 32'hA000_0000 + t);
            else
                check($sformatf("rr%0d.irdata", t), i_rdata, 32'hA000_0000 + t);
            @(negedge clk);
            check($sformatf("rr%0d.idle.rdy", t), {i_ready, d_ready}, 2'b00);
            check($sformatf("rr%0d.idle.busy", t), busy, 0);
            if (t == 3) begin
                i_req = 0; d_req = 0;
            end
        end
        check("rr.final.irdata", i_rdata, 32'hA000_0003);

        // Reset in the second ACCESS cycle
        i_req = 1; i_addr = 32'h500; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("rst.acc1.ren", mem_ren, 1);
        @(posedge clk);
        #2;
        check("rst.acc2.busy", busy, 1);
        reset = 1'b1; i_req = 0;
        #1;
        check_all_zero("rst.abort");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst.after%0d.rdy", k),  i_ready, 0);
            check($sformatf("rst.after%0d.busy", k), busy, 0);
        end

        // MEM_LATENCY = 1, back-to-back instruction reads: ready every 3 cycles
        i1_req = 1; mem1_rdata = 32'h55;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("l1.c%0d.rdy", k), i1_ready, (k % 3 == 2));
            check($sformatf("l1.c%0d.ren", k), mem1_ren, (k % 3 == 1));
        end
        check("l1.data", i1_rdata, 32'h55);
        i1_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
